nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that adds two wide operands by time-multiplexing one instance of the team's existing combinational ripple_carry_adder_4bit (ports A, B, Cin, Sum, Cout), one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Result is assembled in an output register.
- Sits between a requester using a start/busy/done handshake and the shared 4-bit adder datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE or DONE.
A  input  W  operand A; captured on accepted start.
B  input  W  operand B; captured on accepted start.
Cin  input  1  carry-in; captured on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; Sum/Cout valid.
Sum  output  W  result register.
Cout  output  1  final carry-out register.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, idx=0, carry=0, A/B latches=0, Sum=0, Cout=0, busy=0, done=0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: stays in RUN for NIBBLES cycles, then -> DONE.
  - DONE: start=1 -> RUN; otherwise -> IDLE.
  - busy=1 exactly when state=RUN. done=1 exactly when state=DONE, so it is a single cycle.
- Accept (edge where state is IDLE or DONE and start=1):
  - Latch A, B.
  - carry<=Cin, idx<=0, Sum<=0, Cout<=0.
- RUN, each edge:
  - Adder inputs are A_lat[4*idx+:4], B_lat[4*idx+:4], carry.
  - Sum[4*idx+:4]<=adder Sum; carry<=adder Cout.
  - On the last nibble (idx=NIBBLES-1): Cout<=adder Cout, go to DONE.
  - Otherwise idx<=idx+1.
- Latency: start sampled at edge k. Nibbles are written at edges k+1..k+NIBBLES. done is high in the cycle following edge k+NIBBLES.
- Results: Sum and Cout hold their values after DONE until the next accept or reset. Partial Sum is visible during RUN; higher nibbles read 0 until written.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(W+1), unsigned. No overflow flag.
- idx width: clog2(NIBBLES), minimum 1 bit. No wrap beyond NIBBLES-1.
- Busy input rules:
  - start while busy=1: ignored.
  - A, B and Cin changes during RUN: no effect, because operands are latched.
- Back-to-back: start=1 during DONE is accepted, so done and the new accept occur on the same edge. Throughput is one result per NIBBLES+1 cycles.
- NIBBLES=1: RUN lasts one cycle.
- Reset mid-RUN: abort immediately. No done pulse. Outputs go to reset values.
- Exactly one adder instance; no other arithmetic on the operands.

Test Plan:
- NIBBLES=4, basic add: A=16'h1234, B=16'h4321, Cin=0, start one cycle.
  - busy high for 4 cycles, then done pulse.
  - Sum=16'h5555, Cout=0.
- Full carry ripple: A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1. Check partial Sum after each RUN edge: 0000 every step, with carry propagating.
- Maximum operands: A=16'hFFFF, B=16'hFFFF, Cin=1 -> Sum=16'hFFFF, Cout=1.
- Operand change and start while busy: start with A=16'h00FF, B=16'h0001, Cin=0, then change A to 16'h1111 and pulse start during RUN.
  - Result is Sum=16'h0100, Cout=0.
  - Exactly one done pulse.
- Back-to-back: hold start=1 across DONE with the next operands A=16'h8000, B=16'h8000, Cin=1.
  - First done has the prior result.
  - Second done after 4 more cycles with Sum=16'h0001, Cout=1.
- Reset mid-operation: assert rst after 2 RUN cycles.
  - busy, done, Sum and Cout drop to 0 asynchronously.
  - No done pulse.
  - A following start of 16'h0005+16'h0003 gives Sum=16'h0008.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder: one shared 4-bit ripple adder, one nibble per cycle.
// Ports: clk, rst, start, A/B/Cin in; busy, done, Sum, Cout out.
module ripple_carry_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [4:0] c;

  always_comb begin
    c = '0;
    Sum = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [3:0]    add_s;
  logic          add_c;

  // Current nibble selected by shifting the latched operand down.
  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  ripple_carry_adder_4bit u_add (
    .A    (a_sh[3:0]),
    .B    (b_sh[3:0]),
    .Cin  (carry_q),
    .Sum  (add_s),
    .Cout (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) sum_q[4*n +: 4] <= add_s;
          end
          carry_q <= add_c;
          if (idx_q == LAST) begin
            cout_q  <= add_c;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized scoreboard bench for nibble_serial_adder_ctrl.
// Stimulus pushes expected {Cout,Sum}; a monitor pops on each done pulse.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_issued = 0;
  logic [W:0] sb[$];

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("result", 32'({Cout, Sum}), 32'(e));
      end
    end
  end

  // Drive operands and start; the accept edge is the next posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    A = a;
    B = b;
    Cin = c;
    start = 1'b1;
    sb.push_back(model(a, b, c));
    n_issued++;
  endtask

  // Follows one operation to its done cycle, checking partial sums.
  // disturb: change operands and pulse start mid-RUN.
  task automatic wait_result(input logic [W:0] exp, input bit disturb);
    logic [W-1:0] m;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      m = (i == 0) ? '0 : ({W{1'b1}} >> (W - 4 * i));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("partial_sum", 32'(Sum), 32'(exp[W-1:0] & m));
      if (disturb && i == 1) begin
        A = 16'h1111;
        B = 16'h2222;
        Cin = 1'b1;
        start = 1'b1;
      end
      if (disturb && i == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic idle_check(input logic [W:0] exp);
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("hold_result", 32'({Cout, Sum}), 32'(exp));
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c);
    issue(a, b, c);
    wait_result(model(a, b, c), 1'b0);
    idle_check(model(a, b, c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    op(16'h1234, 16'h4321, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1);

    issue(16'h00FF, 16'h0001, 1'b0);
    wait_result(model(16'h00FF, 16'h0001, 1'b0), 1'b1);
    idle_check(model(16'h00FF, 16'h0001, 1'b0));

    // Back-to-back: new start presented during the DONE cycle.
    issue(16'h1234, 16'h4321, 1'b0);
    wait_result(model(16'h1234, 16'h4321, 1'b0), 1'b0);
    issue(16'h8000, 16'h8000, 1'b1);
    wait_result(model(16'h8000, 16'h8000, 1'b1), 1'b0);
    idle_check(model(16'h8000, 16'h8000, 1'b1));

    // Reset in the middle of RUN.
    issue(16'hABCD, 16'h1357, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    void'(sb.pop_back());
    n_issued--;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(Sum), 32'd0);
    chk("arst_cout", 32'(Cout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) idle_check('0);
    op(16'h0005, 16'h0003, 1'b0);

    // Random operations, some back-to-back.
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      wait_result(model(ra, rb, rc), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_check(model(ra, rb, rc));
    end
    idle_check({Cout, Sum});
    repeat (3) @(posedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
